// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment scan driver: segment table,
// off levels and output polarity.
package seg_pkg;

    localparam logic [7:0] SEG_OFF_AH = 8'h00;
    localparam logic [7:0] SEG_OFF_AL = 8'hFF;

    // Active-high {a,b,c,d,e,f,g,dp} pattern per hex nibble; dp bit left clear.
    function automatic logic [7:0] hex2seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hFC;
            4'h1: seg = 8'h60;
            4'h2: seg = 8'hDA;
            4'h3: seg = 8'hF2;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'hB6;
            4'h6: seg = 8'hBE;
            4'h7: seg = 8'hE0;
            4'h8: seg = 8'hFE;
            4'h9: seg = 8'hF6;
            4'hA: seg = 8'hEE;
            4'hB: seg = 8'h3E;
            4'hC: seg = 8'h9C;
            4'hD: seg = 8'h7A;
            4'hE: seg = 8'h9E;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    function automatic logic [7:0] apply_pol(input logic [7:0] seg_ah, input logic active_low);
        return active_low ? ~seg_ah : seg_ah;
    endfunction

    // Digit index width; a single-digit display still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n_digits);
        return (n_digits > 1) ? $clog2(n_digits) : 1;
    endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational nibble-to-segment decoder; emits the active-high byte or the
// off byte when the digit is not visible.
module hex7seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       vis,
    output logic [7:0] seg_c
);

    logic [7:0] raw_c;

    always_comb begin
        raw_c = hex2seg(nib);
        seg_c = SEG_OFF_AH;
        if (vis) begin
            seg_c = {raw_c[7:1], dp};
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Latched multi-digit hex display driver with a time-multiplexed scan bus and
// a static per-digit segment bus.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned N_DIGITS   = 8,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned BLINK_DIV  = 25000000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ld,
    input  logic [4*N_DIGITS-1:0]            data,
    input  logic [N_DIGITS-1:0]              dp_in,
    input  logic [N_DIGITS-1:0]              en_in,
    input  logic [N_DIGITS-1:0]              blink_in,
    output logic [7:0]                       seg_o,
    output logic [N_DIGITS-1:0]              an_o,
    output logic [8*N_DIGITS-1:0]            seg_all,
    output logic [idx_width(N_DIGITS)-1:0]   idx_o
);

    localparam int unsigned IDX_W   = idx_width(N_DIGITS);
    localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
    localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

    localparam logic [7:0]          SEG_OFF = ACTIVE_LOW ? SEG_OFF_AL : SEG_OFF_AH;
    localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{ACTIVE_LOW}};

    logic [4*N_DIGITS-1:0] sh_data;
    logic [N_DIGITS-1:0]   sh_dp;
    logic [N_DIGITS-1:0]   sh_en;
    logic [N_DIGITS-1:0]   sh_blink;

    logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  phase_q, phase_d;

    logic [N_DIGITS-1:0]   vis_c;
    logic [3:0]            scan_nib_c;
    logic                  scan_dp_c;
    logic                  scan_vis_c;
    logic [7:0]            scan_seg_c;
    logic [N_DIGITS-1:0]   an_c;
    logic [8*N_DIGITS-1:0] all_seg_c;

    // Shadow registers: all four vectors replaced together on ld.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_data  <= '0;
            sh_dp    <= '0;
            sh_en    <= '0;
            sh_blink <= '0;
        end else if (ld) begin
            sh_data  <= data;
            sh_dp    <= dp_in;
            sh_en    <= en_in;
            sh_blink <= blink_in;
        end
    end

    // Scan and blink position state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q  <= '0;
            blink_cnt_q <= '0;
            idx_q       <= '0;
            phase_q     <= 1'b0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            idx_q       <= idx_d;
            phase_q     <= phase_d;
        end
    end

    always_comb begin
        scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        idx_d       = idx_q;
        phase_d     = phase_q;
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    // Output stage is built from the upcoming position so the index change is
    // seen at once, while shadow data always lags its load by one register.
    always_comb begin
        vis_c      = sh_en & ~(sh_blink & {N_DIGITS{phase_d}});
        scan_nib_c = sh_data[4*int'(idx_d) +: 4];
        scan_dp_c  = sh_dp[idx_d];
        scan_vis_c = vis_c[idx_d];
        an_c       = '0;
        if (scan_vis_c) begin
            an_c = N_DIGITS'(1) << idx_d;
        end
    end

    hex7seg_dec u_scan_dec (
        .nib   (scan_nib_c),
        .dp    (scan_dp_c),
        .vis   (scan_vis_c),
        .seg_c (scan_seg_c)
    );

    for (genvar k = 0; k < int'(N_DIGITS); k++) begin : g_static
        hex7seg_dec u_dec (
            .nib   (sh_data[4*k +: 4]),
            .dp    (sh_dp[k]),
            .vis   (vis_c[k]),
            .seg_c (all_seg_c[8*k +: 8])
        );
    end

    // Scan and static buses share one register stage so segments and anode move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_o   <= SEG_OFF;
            an_o    <= AN_OFF;
            seg_all <= {N_DIGITS{SEG_OFF}};
        end else begin
            seg_o   <= apply_pol(scan_seg_c, ACTIVE_LOW);
            an_o    <= ACTIVE_LOW ? ~an_c : an_c;
            seg_all <= ACTIVE_LOW ? ~all_seg_c : all_seg_c;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (4 digits, scan 4, blink 16, active-low) using
// vector tables, hand sequences and a cycle-count based reference model.
module tb_seg_scan_driver;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld;
    logic [15:0] data;
    logic [3:0]  dp_in, en_in, blink_in;
    logic [7:0]  seg_o;
    logic [3:0]  an_o;
    logic [31:0] seg_all;
    logic [1:0]  idx_o;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .N_DIGITS   (4),
        .SCAN_DIV   (4),
        .BLINK_DIV  (16),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld       (ld),
        .data     (data),
        .dp_in    (dp_in),
        .en_in    (en_in),
        .blink_in (blink_in),
        .seg_o    (seg_o),
        .an_o     (an_o),
        .seg_all  (seg_all),
        .idx_o    (idx_o)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    endtask

    // Reference model: position follows from the edge count since reset,
    // shadow contents from the last ld seen on an earlier edge.
    logic [7:0]  tbl [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                              8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    int          n;
    logic [15:0] m_data;
    logic [3:0]  m_dp, m_en, m_bl;

    function automatic bit m_vis(input int k, input int nn);
        return m_en[k] && !(m_bl[k] && (((nn / BD) % 2) == 1));
    endfunction

    function automatic logic [7:0] m_byte(input int k, input int nn);
        logic [7:0] b;
        b = m_vis(k, nn) ? (tbl[m_data[4*k +: 4]] | {7'b0, m_dp[k]}) : 8'h00;
        return ~b;
    endfunction

    task automatic model_reset();
        n = 0; m_data = '0; m_dp = '0; m_en = '0; m_bl = '0;
    endtask

    task automatic step();
        logic        ld_s;
        logic [15:0] d_s;
        logic [3:0]  dp_s, en_s, bl_s;
        int          ei;
        logic [7:0]  e_seg;
        logic [3:0]  e_an;
        logic [31:0] e_all;
        ld_s = ld; d_s = data; dp_s = dp_in; en_s = en_in; bl_s = blink_in;
        @(posedge clk);
        n++;
        ei    = (n / SD) % N;
        e_seg = m_byte(ei, n);
        e_an  = 4'hF;
        if (m_vis(ei, n)) e_an[ei] = 1'b0;
        for (int k = 0; k < N; k++) e_all[8*k +: 8] = m_byte(k, n);
        if (ld_s) begin
            m_data = d_s; m_dp = dp_s; m_en = en_s; m_bl = bl_s;
        end
        #1;
        check("model_idx", 32'(idx_o), 32'(ei));
        check("model_seg", 32'(seg_o), 32'(e_seg));
        check("model_an", 32'(an_o), 32'(e_an));
        check("model_seg_all", seg_all, e_all);
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                        input logic [3:0] bl);
        data = d; dp_in = dp; en_in = en; blink_in = bl; ld = 1'b1;
        step();
        ld = 1'b0;
    endtask

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [31:0] exp_all;
    } vec_t;

    vec_t tv [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int         found;
        int         vis_cnt0, vis_cnt1, wi;
        logic [7:0] old_b [4];

        tv[0] = '{16'h3A0F, 4'b0100, 4'hF,    32'h0D10_0371};
        tv[1] = '{16'h3A0F, 4'b0100, 4'b0101, 32'hFF10_FF71};
        tv[2] = '{16'h8421, 4'b1111, 4'hF,    32'h0098_249E};
        tv[3] = '{16'h0000, 4'b0000, 4'h0,    32'hFFFF_FFFF};
        tv[4] = '{16'hBCDE, 4'b0000, 4'hF,    32'hC163_8561};
        tv[5] = '{16'h5679, 4'b0000, 4'hF,    32'h4941_1F09};
        old_b = '{8'h09, 8'h1F, 8'h41, 8'h49};

        rst_n = 1'b0; ld = 1'b0; data = '0; dp_in = '0; en_in = '0; blink_in = '0;
        model_reset();
        repeat (5) @(posedge clk);
        #1;
        check("rst_seg", 32'(seg_o), 32'hFF);
        check("rst_an", 32'(an_o), 32'hF);
        check("rst_seg_all", seg_all, 32'hFFFF_FFFF);
        check("rst_idx", 32'(idx_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();

        // Static decode table.
        foreach (tv[i]) begin
            load(tv[i].data, tv[i].dp, tv[i].en, 4'b0000);
            step();
            check("tbl_seg_all", seg_all, tv[i].exp_all);
        end

        // Scan: digit 2 of 3A0F shows 'A' with dp on its own anode.
        load(16'h3A0F, 4'b0100, 4'hF, 4'b0000);
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            step();
            if (idx_o == 2'd2) found = 1;
        end
        check("scan_reach_idx2", 32'(found), 32'd1);
        check("scan_an_idx2", 32'(an_o), 32'b1011);
        check("scan_seg_idx2", 32'(seg_o), 32'h10);
        repeat (16) step();

        // Enable mask: blanked digits keep all anodes off during their slot.
        load(16'h3A0F, 4'b0100, 4'b0101, 4'b0000);
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            step();
            if (idx_o == 2'd3) found = 1;
        end
        check("mask_reach_idx3", 32'(found), 32'd1);
        check("mask_an_idx3", 32'(an_o), 32'hF);
        check("mask_seg_idx3", 32'(seg_o), 32'hFF);

        // Blink: over any 64 cycles digit 0 is lit exactly half the time.
        load(16'h0000, 4'b0000, 4'hF, 4'b0001);
        step();
        vis_cnt0 = 0; vis_cnt1 = 0;
        for (int c = 0; c < 64; c++) begin
            step();
            if (seg_all[7:0] == 8'h03) vis_cnt0++;
            if (seg_all[15:8] == 8'h03) vis_cnt1++;
        end
        check("blink_d0_lit", 32'(vis_cnt0), 32'd32);
        check("blink_d1_lit", 32'(vis_cnt1), 32'd64);

        // ld coinciding with an index wrap.
        load(16'h5679, 4'b0000, 4'hF, 4'b0000);
        repeat (2) step();
        found = 0;
        for (int c = 0; c < 8 && found == 0; c++) begin
            if ((n % SD) == SD - 1) found = 1;
            else step();
        end
        check("wrap_reach_cnt3", 32'(found), 32'd1);
        load(16'h1111, 4'b0000, 4'hF, 4'b0000);
        wi = (n / SD) % N;
        check("wrap_idx", 32'(idx_o), 32'(wi));
        check("wrap_old_seg", 32'(seg_o), 32'(old_b[wi]));
        step();
        check("wrap_idx_hold", 32'(idx_o), 32'(wi));
        check("wrap_new_seg", 32'(seg_o), 32'h9F);

        // Random loads and inputs against the model.
        for (int c = 0; c < 400; c++) begin
            data     = 16'($urandom);
            dp_in    = 4'($urandom);
            en_in    = 4'($urandom);
            blink_in = 4'($urandom);
            ld       = ($urandom_range(0, 5) == 0);
            step();
        end
        ld = 1'b0;

        // Asynchronous reset mid-scan clears outputs before the next edge.
        load(16'h3A0F, 4'b1111, 4'hF, 4'b0000);
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_seg", 32'(seg_o), 32'hFF);
        check("arst_an", 32'(an_o), 32'hF);
        check("arst_seg_all", seg_all, 32'hFFFF_FFFF);
        check("arst_idx", 32'(idx_o), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Parametrised hex-to-7-segment display driver for the keyboard/display labs. It replaces single-digit table lookup with a latched multi-digit display.
- Holds N_DIGITS hex values plus per-digit decimal point, enable and blink attributes in shadow registers, updated by a load strobe.
- Drives a time-multiplexed segment/anode bus and a static per-digit segment bus for boards that wire every digit directly.

Parameters:
N_DIGITS, 8, number of digits (1..16)
SCAN_DIV, 1000, clk cycles each digit stays selected on the scan bus (>=2)
BLINK_DIV, 25000000, clk cycles per blink half-period (>=2)
ACTIVE_LOW, 1, 1 = segment and anode outputs active-low; 0 = active-high

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
ld  in  1  load strobe; captures data/dp_in/en_in/blink_in on this edge
data  in  4*N_DIGITS  hex nibble per digit; digit k = data[4k+3:4k]
dp_in  in  N_DIGITS  decimal point per digit
en_in  in  N_DIGITS  digit enable; 0 = digit blank
blink_in  in  N_DIGITS  1 = digit blinks
seg_o  out  8  scan-bus segments {a,b,c,d,e,f,g,dp}, bit7 = a
an_o  out  N_DIGITS  scan-bus digit select, one-hot active
seg_all  out  8*N_DIGITS  static segments; digit k = seg_all[8k+7:8k]
idx_o  out  max(1,clog2(N_DIGITS))  index of digit currently on scan bus

Behaviour:
- The clock is clk. Reset is rst_n: asynchronous assert, active-low, synchronous release. Asserting rst_n mid-operation clears all state immediately, without waiting for a clock edge.
- Reset state:
  - Shadow data, dp, en and blink are all 0.
  - Scan counter, digit index and blink counter are 0; blink phase is 0.
  - All outputs are at the "off" level: seg_o and every seg_all byte = 8'hFF (ACTIVE_LOW=1) or 8'h00; an_o all deasserted; idx_o = 0.
- Decode, with 1 = segment lit before polarity is applied:
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0
  - 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E
  - bit0 (dp) is replaced by the shadow dp bit.
- Load:
  - When ld=1 at a rising clk, all four shadow vectors are replaced atomically.
  - Outputs reflect the new values one cycle later, through the registered outputs.
  - With ld=0 the shadow registers hold.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the digit index advances by 1 modulo N_DIGITS; N_DIGITS-1 -> 0. With N_DIGITS=1 the index stays 0.
- Blink:
  - The blink counter counts 0..BLINK_DIV-1; on wrap the blink phase toggles.
  - Neither counter is affected by ld.
- Visibility:
  - Digit k is visible when en[k]=1 and !(blink[k] & phase).
  - A visible digit outputs its decoded byte; an invisible digit outputs the off byte.
  - On the scan bus, an_o asserts only bit idx, and only when digit idx is visible; otherwise an_o is all-off.
- Latency and glitch freedom:
  - seg_o, an_o, idx_o and seg_all are all registered, one cycle after the state they depend on.
  - seg_o and an_o change in the same cycle, so the bus never pairs one digit's segments with another digit's anode.
- Simultaneous events: if ld coincides with an index wrap, the next cycle shows the new index with the old shadow values. The following cycle shows the new shadow values. There is no lost or partial update.
- Widths: scan counter is clog2(SCAN_DIV); blink counter is clog2(BLINK_DIV); index is max(1, clog2(N_DIGITS)). No counter may exceed its terminal value.

Decomposition:
- Shared package seg_pkg holds:
  - the 16-entry hex-to-segment table as a constant function;
  - SEG_OFF_AH (8'h00) and SEG_OFF_AL (8'hFF);
  - a polarity helper function.
- One combinational sub-module, hex7seg_dec (nibble + dp + visible -> 8-bit active-high byte):
  - instantiated once for the scan path;
  - instantiated N_DIGITS times in a generate loop for seg_all.
- Polarity inversion is applied once, at the output registers.

Test Plan:
All scenarios use N_DIGITS=4, SCAN_DIV=4, BLINK_DIV=16, ACTIVE_LOW=1.
- Reset: hold rst_n=0 for 5 cycles, then release -> seg_o=FF, an_o=4'b1111, seg_all=32'hFFFFFFFF, idx_o=0. Assert rst_n low asynchronously mid-scan -> the same values appear before the next clk edge.
- Load and static decode: ld with data=16'h3A0F, en=4'hF, dp=4'b0100, blink=0 -> one cycle later seg_all = {~F2, ~EF, ~FC, ~8E} = 32'h0D10_0371.
- Scan: after the load above, idx_o steps 0,1,2,3,0 every 4 cycles; an_o = 1110, 1101, 1011, 0111. seg_o matches the selected digit's byte in the same cycle as its anode.
- Enable mask: en=4'b0101 -> digits 1 and 3 give seg_o=FF with an_o all ones during their slots; seg_all bytes 1 and 3 = FF.
- Blink: blink=4'b0001 -> digit 0 is visible for 16 cycles, blank for 16 cycles, repeating; the other digits are unaffected.
- ld on wrap: pulse ld with data=16'h1111 in the cycle the scan counter is at 3 -> the next idx shows its old digit for one cycle, then 60 is decoded (seg_o=9F).
